mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32-bit mux8 datapath mux among 8 requesters.
//  Grants at most one requester at a time, drives the mux8 select, holds the grant
//  until the owner releases it or a hold limit expires, then hands off with a
//  one-cycle bubble. Sits between requesting units and the shared mux/bus.
// PARAMETERS
//  MAX_HOLD  16  max consecutive OWN cycles per grant (legal range >= 2)
//  SEL_W     5   width of sel output; matches the mux8 select port
//  CNT_W     5   width of hold counter; must hold MAX_HOLD-1
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      synchronous, active-high
//  req       in   8      request per requester, level-sensitive
//  release   in   1      owner ends its transaction; ignored unless busy=1
//  grant     out  8      one-hot grant, all-zero when no owner (registered)
//  sel       out  SEL_W  winner index, zero-extended; drives mux8 select (registered)
//  busy      out  1      1 while in OWN
//  timeout   out  1      1-cycle pulse when a grant is revoked by the hold limit
// BEHAVIOUR
//  Reset (reset=1 at an edge): state=IDLE, grant=0, sel=0, busy=0, timeout=0,
//   hold_cnt=0, last_winner=7 (requester 0 has top priority first). Wins at any
//   state, including mid-grant; grant drops on that same edge.
//  States: IDLE, OWN, HANDOFF. All outputs are registered and change only at edges.
//  Arbitration (evaluated in IDLE and HANDOFF): search req starting at
//   last_winner+1, wrapping mod 8; first set bit wins. None set -> go/stay IDLE.
//  IDLE: if any req at edge -> OWN; grant=onehot(w), sel=w, last_winner=w,
//   hold_cnt=0, busy=1. Latency: req high in cycle N -> grant high in cycle N+1.
//  OWN: hold_cnt increments every cycle. End condition in a cycle:
//   release=1, or req[owner]=0, or hold_cnt==MAX_HOLD-1.
//   On end -> HANDOFF; grant=0, busy=0. timeout=1 for that HANDOFF cycle only
//   when the end is solely due to the hold limit (release/req drop take priority).
//   Net: owner holds grant for at most MAX_HOLD cycles.
//  HANDOFF: exactly one cycle, grant=0 (bubble, no mux contention). Arbitrates:
//   any req -> OWN with the new winner, else -> IDLE. Minimum gap between
//   successive grants is one cycle.
//  sel: updated only on the edge that enters OWN; held through HANDOFF/IDLE.
//   Bits [SEL_W-1:3] always 0.
//  Fairness: revoked/released owner becomes lowest priority; a lone requester
//   is re-granted after the bubble.
//  Requests arriving/dropping in OWN for non-owners have no effect until HANDOFF.
//  release while not busy: ignored. grant is never multi-hot; never nonzero in
//   IDLE/HANDOFF.
// TESTING
//  Reset, then req=8'hFF held -> grants in order 0,1,2,...,7,0 with one zero-grant
//   cycle between each; sel tracks 0..7.
//  req=8'h01 held, no release, MAX_HOLD=16 -> grant=8'h01 for 16 cycles,
//   timeout pulse 1 cycle, bubble, grant=8'h01 again.
//  Owner 3 (req=8'h28), release at 2nd OWN cycle -> HANDOFF next, then grant=8'h20,
//   sel=5, timeout stays 0.
//  Owner 2 drops req[2] mid-grant with req[6]=1 -> grant 0 for 1 cycle, then 8'h40.
//  reset=1 during OWN of requester 4 -> next cycle grant=0, sel=0; after reset
//   with req=8'h11, requester 0 wins first.
//  release=1 while IDLE and req=0 -> no state change, all outputs remain 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 32-bit mux8 datapath: one-hot grant, registered
// select, hold-limit revocation and a one-cycle bubble between successive owners.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int SEL_W    = 5,
    parameter int CNT_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic             owner_release,
    output logic [7:0]       grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_OWN     = 2'd1;
    localparam logic [1:0]       ST_HANDOFF = 2'd2;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

    // Returns {found, index}; scanning offsets high-to-low lets the nearest
    // requester after 'last' overwrite farther ones.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 8; i >= 1; i--) begin
            idx = last + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [7:0]       grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       last_winner_q, last_winner_d;
    logic [3:0]       pick_s;
    logic             rel_end_s, drop_end_s, limit_end_s;

    // Next-state and next-output computation for the IDLE/OWN/HANDOFF machine.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        busy_d        = busy_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        last_winner_d = last_winner_q;
        pick_s        = rr_pick(req, last_winner_q);
        rel_end_s     = owner_release;
        drop_end_s    = ~req[last_winner_q];
        limit_end_s   = (hold_cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE, ST_HANDOFF: begin
                if (pick_s[3]) begin
                    state_d       = ST_OWN;
                    grant_d       = 8'd1 << pick_s[2:0];
                    sel_d         = SEL_W'(pick_s[2:0]);
                    last_winner_d = pick_s[2:0];
                    hold_cnt_d    = '0;
                    busy_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            ST_OWN: begin
                if (rel_end_s || drop_end_s || limit_end_s) begin
                    state_d    = ST_HANDOFF;
                    grant_d    = 8'd0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    // Revocation is flagged only when the owner still wanted the bus.
                    timeout_d  = limit_end_s & ~rel_end_s & ~drop_end_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 8'd0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 8'd0;
            sel_q         <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            last_winner_q <= 3'd7;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: an abstract ownership model checked every
// cycle, plus hand-computed literal expectations along the scenario.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int SEL_W    = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [7:0]       req;
    logic             owner_release;
    logic [7:0]       grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode 0 = no owner, 1 = owning, 2 = bubble
    int         m_mode  = 0;
    int         m_owner = 0;
    int         m_cnt   = 0;
    int         m_last  = 7;
    int         m_sel   = 0;
    int         w;
    logic [7:0] m_grant = 8'h00;
    bit         m_busy  = 1'b0;
    bit         m_to    = 1'b0;
    bit         m_valid = 1'b0;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .SEL_W(SEL_W), .CNT_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .owner_release (owner_release),
        .grant         (grant),
        .sel           (sel),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    function automatic int pick_next(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    // Ownership model advanced on each rising edge from the sampled inputs.
    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1'b1;
            m_mode  = 0;
            m_grant = 8'h00;
            m_sel   = 0;
            m_busy  = 1'b0;
            m_to    = 1'b0;
            m_cnt   = 0;
            m_last  = 7;
        end else if (m_valid) begin
            if (m_mode == 1) begin
                if (owner_release || !req[m_owner] || m_cnt == MAX_HOLD) begin
                    m_to    = !owner_release && req[m_owner];
                    m_mode  = 2;
                    m_grant = 8'h00;
                    m_busy  = 1'b0;
                end else begin
                    m_cnt++;
                    m_to = 1'b0;
                end
            end else begin
                m_to = 1'b0;
                w    = pick_next(req, m_last);
                if (w >= 0) begin
                    m_mode  = 1;
                    m_owner = w;
                    m_last  = w;
                    m_cnt   = 1;
                    m_grant = 8'h01 << w;
                    m_sel   = w;
                    m_busy  = 1'b1;
                end else begin
                    m_mode  = 0;
                    m_grant = 8'h00;
                    m_busy  = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("grant",   int'(grant),   int'(m_grant));
            chk("sel",     int'(sel),     m_sel);
            chk("busy",    int'(busy),    int'(m_busy));
            chk("timeout", int'(timeout), int'(m_to));
            chk("onehot",  int'($countones(grant) <= 1), 1);
        end
    end

    initial begin
        reset         = 1'b1;
        req           = 8'h00;
        owner_release = 1'b0;
        nxt();
        nxt();
        chk("rst_grant",   int'(grant),   0);
        chk("rst_sel",     int'(sel),     0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_timeout", int'(timeout), 0);

        // release while idle with no requests is ignored
        reset         = 1'b0;
        owner_release = 1'b1;
        repeat (3) nxt();
        chk("idle_rel_grant", int'(grant), 0);
        chk("idle_rel_busy",  int'(busy),  0);
        chk("idle_rel_sel",   int'(sel),   0);
        owner_release = 1'b0;

        // all requesting, each owner releases at once: 0..7 then 0 again
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            nxt();
            chk("rr_grant", int'(grant), 1 << (k % 8));
            chk("rr_sel",   int'(sel),   k % 8);
            owner_release = 1'b1;
            nxt();
            chk("rr_bubble", int'(grant), 0);
            owner_release = 1'b0;
        end
        req = 8'h00;
        nxt();
        nxt();
        chk("rr_idle_busy", int'(busy), 0);

        // lone requester held past the limit
        req = 8'h01;
        for (int i = 0; i < 16; i++) begin
            nxt();
            chk("hold_grant",   int'(grant),   1);
            chk("hold_timeout", int'(timeout), 0);
        end
        nxt();
        chk("limit_grant",   int'(grant),   0);
        chk("limit_timeout", int'(timeout), 1);
        nxt();
        chk("regrant_grant",   int'(grant),   1);
        chk("regrant_timeout", int'(timeout), 0);
        req = 8'h00;
        nxt();
        nxt();

        // owner 3 releases in its second cycle, 5 follows
        req = 8'h28;
        nxt();
        chk("rel_grant3", int'(grant), 8);
        chk("rel_sel3",   int'(sel),   3);
        nxt();
        owner_release = 1'b1;
        nxt();
        chk("rel_bubble",  int'(grant),   0);
        chk("rel_timeout", int'(timeout), 0);
        owner_release = 1'b0;
        nxt();
        chk("rel_grant5",   int'(grant),   32);
        chk("rel_sel5",     int'(sel),     5);
        chk("rel_timeout2", int'(timeout), 0);
        req = 8'h00;
        nxt();
        nxt();

        // owner 2 drops its request while 6 waits
        req = 8'h04;
        nxt();
        chk("drop_grant2", int'(grant), 4);
        chk("drop_sel2",   int'(sel),   2);
        req = 8'h44;
        nxt();
        chk("drop_hold2", int'(grant), 4);
        req = 8'h40;
        nxt();
        chk("drop_bubble", int'(grant), 0);
        nxt();
        chk("drop_grant6", int'(grant), 64);
        chk("drop_sel6",   int'(sel),   6);

        // reset in the middle of requester 4's grant
        req = 8'h10;
        nxt();
        chk("pre_rst_bubble", int'(grant), 0);
        nxt();
        chk("pre_rst_grant4", int'(grant), 16);
        chk("pre_rst_sel4",   int'(sel),   4);
        reset = 1'b1;
        nxt();
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_sel",   int'(sel),   0);
        chk("mid_rst_busy",  int'(busy),  0);
        reset = 1'b0;
        req   = 8'h11;
        nxt();
        chk("post_rst_grant0", int'(grant), 1);
        chk("post_rst_sel0",   int'(sel),   0);
        owner_release = 1'b1;
        nxt();
        chk("post_rst_bubble", int'(grant), 0);
        owner_release = 1'b0;
        nxt();
        chk("post_rst_grant4", int'(grant), 16);
        chk("post_rst_sel4",   int'(sel),   4);
        req           = 8'h00;
        owner_release = 1'b1;
        repeat (3) nxt();
        owner_release = 1'b0;
        nxt();
        chk("end_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
